// File: rtl/result_checker.sv
// result_checker: compares captured response words against masked expected values,
// keeps saturating pass/fail counts, and emits one record per mismatching vector.
module result_checker #(
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int CNT_WIDTH   = 16,
  parameter int IDX_WIDTH   = 16,
  parameter int FAIL_WIDTH  = IDX_WIDTH + CYCLE_RANGE + 1 + RTF_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             res_valid,
  output logic                             res_ready,
  input  logic [RTF_WIDTH+CYCLE_RANGE:0]   res_data,
  input  logic                             exp_valid,
  output logic                             exp_ready,
  input  logic [RTF_WIDTH-1:0]             exp_data,
  input  logic [RTF_WIDTH-1:0]             exp_mask,
  input  logic                             exp_last,
  output logic                             fail_valid,
  input  logic                             fail_ready,
  output logic [FAIL_WIDTH-1:0]            fail_data,
  output logic [CNT_WIDTH-1:0]             pass_count,
  output logic [CNT_WIDTH-1:0]             fail_count,
  output logic [IDX_WIDTH-1:0]             first_fail_idx,
  output logic                             first_fail_valid,
  output logic                             busy,
  output logic                             done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [IDX_WIDTH-1:0] index;
  logic [RTF_WIDTH-1:0] diff;
  logic mismatch, xfer;
  assign diff     = (res_data[RTF_WIDTH-1:0] ^ exp_data) & exp_mask;
  assign mismatch = |diff;
  // Both streams move together, and only when a new record could be stored.
  assign xfer      = !start && state == RUN && res_valid && exp_valid && (!fail_valid || fail_ready);
  assign res_ready = xfer;
  assign exp_ready = xfer;
  assign busy      = state == RUN || state == DRAIN;
  assign done      = state == DONE;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      index            <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      fail_valid       <= 1'b0;
      fail_data        <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else if (start) begin
      state            <= RUN;
      index            <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      fail_valid       <= 1'b0;
      fail_data        <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      if (fail_valid && fail_ready) fail_valid <= 1'b0;
      if (xfer) begin
        index <= index + 1'b1;
        state <= exp_last ? DRAIN : RUN;
        if (mismatch) begin
          fail_count <= fail_count + CNT_WIDTH'(~&fail_count);
          fail_valid <= 1'b1;
          fail_data  <= {index, res_data[RTF_WIDTH+CYCLE_RANGE:RTF_WIDTH], diff};
          if (!first_fail_valid) begin
            first_fail_idx   <= index;
            first_fail_valid <= 1'b1;
          end
        end else begin
          pass_count <= pass_count + CNT_WIDTH'(~&pass_count);
        end
      end
      if (state == DRAIN && (!fail_valid || fail_ready)) state <= DONE;
    end
  end
endmodule
